// File: rtl/drive_pkg.sv
// Shared state codes and default tuning for the drive mode scheduler.
// Imported by the scheduler top and its speed ramp.
package drive_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DRIVER   = 3'd1,
        S_AUTO     = 3'd2,
        S_BRAKE    = 3'd3,
        S_STOPPING = 3'd4
    } state_t;

    localparam int SAFE_DIST_DEF = 10;
    localparam int HYST_DEF      = 5;
    localparam int RAMP_STEP_DEF = 2;

    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/speed_ramp.sv
// Next setpoint: clamp or ramp up toward cap, ramp down while stopping,
// zero otherwise.
module speed_ramp
    import drive_pkg::*;
#(
    parameter int RAMP_STEP = RAMP_STEP_DEF
) (
    input  logic [7:0] cap,
    input  state_t     mode,
    input  logic [7:0] cur,
    output logic [7:0] nxt
);

    localparam logic [8:0] STEP9 = 9'(RAMP_STEP);

    logic [8:0] diff;

    always_comb begin
        nxt  = '0;
        diff = {1'b0, cap} - {1'b0, cur};
        unique case (mode)
            S_DRIVER, S_AUTO: begin
                if (cur > cap)
                    nxt = cap;
                else
                    nxt = 8'({1'b0, cur} + ((diff < STEP9) ? diff : STEP9));
            end
            S_STOPPING: begin
                if ({1'b0, cur} >= STEP9)
                    nxt = 8'({1'b0, cur} - STEP9);
            end
            default: nxt = '0;
        endcase
    end

endmodule

// File: rtl/drive_mode_scheduler.sv
// Arbitrates driver/autopilot control, forces braking on short gaps,
// and ramps the speed setpoint.
module drive_mode_scheduler
    import drive_pkg::*;
#(
    parameter int SAFE_DIST = SAFE_DIST_DEF,
    parameter int HYST      = HYST_DEF,
    parameter int RAMP_STEP = RAMP_STEP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] speed_limit,
    input  logic [7:0] car_speed,
    input  logic [6:0] leading_distance,
    input  logic       unlock_doors,
    input  logic       drv_req,
    input  logic [7:0] drv_target,
    input  logic       auto_req,
    input  logic [7:0] auto_target,
    output logic       accelerate_car,
    output logic       brake_car,
    output logic       door_locked,
    output logic       grant_drv,
    output logic       grant_auto,
    output logic [2:0] mode,
    output logic [7:0] target_speed
);

    localparam logic [8:0] SAFE9 = 9'(SAFE_DIST);
    localparam logic [8:0] EXIT9 = 9'(SAFE_DIST + HYST);

    state_t     state, next_state;
    logic [7:0] cap, ramp_nxt, target_nxt;
    logic       door_nxt;
    logic [8:0] ld9;
    logic       too_close;

    assign ld9       = {2'b00, leading_distance};
    assign too_close = ld9 < SAFE9;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            target_speed <= '0;
            door_locked  <= 1'b1;
        end else begin
            state        <= next_state;
            target_speed <= target_nxt;
            door_locked  <= door_nxt;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (drv_req)       next_state = S_DRIVER;
                else if (auto_req) next_state = S_AUTO;
            end
            S_DRIVER: begin
                if (too_close)     next_state = S_BRAKE;
                else if (!drv_req) next_state = auto_req ? S_AUTO : S_STOPPING;
            end
            S_AUTO: begin
                if (too_close)      next_state = S_BRAKE;
                else if (drv_req)   next_state = S_DRIVER;
                else if (!auto_req) next_state = S_STOPPING;
            end
            S_STOPPING: begin
                if (too_close)     next_state = S_BRAKE;
                else if (drv_req)  next_state = S_DRIVER;
                else if (auto_req) next_state = S_AUTO;
                else if (car_speed == 8'd0 && target_speed == 8'd0)
                    next_state = S_IDLE;
            end
            S_BRAKE: begin
                if (ld9 >= EXIT9) begin
                    if (drv_req)       next_state = S_DRIVER;
                    else if (auto_req) next_state = S_AUTO;
                    else               next_state = S_STOPPING;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // The setpoint follows the state being entered, so a grant change
    // and its new cap land on the same edge.
    always_comb begin
        cap = (next_state == S_DRIVER) ? min8(drv_target, speed_limit)
                                       : min8(auto_target, speed_limit);
        if (state == S_BRAKE && next_state != S_BRAKE)
            target_nxt = min8(car_speed, speed_limit);
        else
            target_nxt = ramp_nxt;
    end

    speed_ramp #(.RAMP_STEP(RAMP_STEP)) u_ramp (
        .cap  (cap),
        .mode (next_state),
        .cur  (target_speed),
        .nxt  (ramp_nxt)
    );

    always_comb begin
        door_nxt = door_locked;
        if (next_state != S_IDLE)
            door_nxt = 1'b1;
        else if (state == S_IDLE && unlock_doors && car_speed == 8'd0)
            door_nxt = 1'b0;
    end

    assign mode           = state;
    assign grant_drv      = (state == S_DRIVER);
    assign grant_auto     = (state == S_AUTO);
    assign brake_car      = (state == S_BRAKE);
    assign accelerate_car = (state == S_DRIVER || state == S_AUTO ||
                             state == S_STOPPING) && (car_speed < target_speed);

endmodule

// File: tb/tb_drive_mode_scheduler.sv
// Directed-vector bench for drive_mode_scheduler.
// Expected values are hand-computed per scenario.
module tb_drive_mode_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] speed_limit;
    logic [7:0] car_speed;
    logic [6:0] leading_distance;
    logic       unlock_doors;
    logic       drv_req;
    logic [7:0] drv_target;
    logic       auto_req;
    logic [7:0] auto_target;
    logic       accelerate_car;
    logic       brake_car;
    logic       door_locked;
    logic       grant_drv;
    logic       grant_auto;
    logic [2:0] mode;
    logic [7:0] target_speed;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    drive_mode_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .speed_limit      (speed_limit),
        .car_speed        (car_speed),
        .leading_distance (leading_distance),
        .unlock_doors     (unlock_doors),
        .drv_req          (drv_req),
        .drv_target       (drv_target),
        .auto_req         (auto_req),
        .auto_target      (auto_target),
        .accelerate_car   (accelerate_car),
        .brake_car        (brake_car),
        .door_locked      (door_locked),
        .grant_drv        (grant_drv),
        .grant_auto       (grant_auto),
        .mode             (mode),
        .target_speed     (target_speed)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        vectors++;
        if ({mode, target_speed, door_locked, grant_drv, grant_auto,
             brake_car, accelerate_car} !== {3'd0, 8'd0, 1'b1, 4'b0000}) begin
            miscompares++;
            $display("FAIL reset: mode=%0d tgt=%0d door=%b gd=%b ga=%b brk=%b acc=%b, want 0 0 1 0 0 0 0",
                     mode, target_speed, door_locked, grant_drv, grant_auto,
                     brake_car, accelerate_car);
        end
        rst = 1'b0;
    endtask

    task automatic test_ramp_up();
        drv_req = 1'b1; drv_target = 8'd60; speed_limit = 8'd50; car_speed = 8'd0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            vectors++;
            if ({grant_drv, accelerate_car, target_speed} !== {2'b11, 8'(2 * i)}) begin
                miscompares++;
                $display("FAIL ramp_up[%0d]: gd=%b acc=%b tgt=%0d, want 1 1 %0d",
                         i, grant_drv, accelerate_car, target_speed, 2 * i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (target_speed !== 8'd50) begin
                miscompares++;
                $display("FAIL ramp_hold: tgt=%0d, want 50", target_speed);
            end
        end
        car_speed = 8'd50;
        #1;
        vectors++;
        if (accelerate_car !== 1'b0) begin
            miscompares++;
            $display("FAIL accel_at_target: acc=%b, want 0", accelerate_car);
        end
    endtask

    task automatic test_preempt();
        drv_req = 1'b0; auto_req = 1'b1; auto_target = 8'd40;
        tick();
        vectors++;
        if ({mode, grant_auto, grant_drv, target_speed} !== {3'd2, 2'b10, 8'd40}) begin
            miscompares++;
            $display("FAIL to_auto: mode=%0d ga=%b gd=%b tgt=%0d, want 2 1 0 40",
                     mode, grant_auto, grant_drv, target_speed);
        end
        drv_req = 1'b1; drv_target = 8'd30;
        tick();
        vectors++;
        if ({mode, grant_auto, grant_drv, target_speed} !== {3'd1, 2'b01, 8'd30}) begin
            miscompares++;
            $display("FAIL preempt: mode=%0d ga=%b gd=%b tgt=%0d, want 1 0 1 30",
                     mode, grant_auto, grant_drv, target_speed);
        end
    endtask

    task automatic test_brake();
        car_speed = 8'd25; leading_distance = 7'd9;
        tick();
        vectors++;
        if ({mode, brake_car, accelerate_car, grant_drv, target_speed} !==
            {3'd3, 3'b100, 8'd0}) begin
            miscompares++;
            $display("FAIL brake_enter: mode=%0d brk=%b acc=%b gd=%b tgt=%0d, want 3 1 0 0 0",
                     mode, brake_car, accelerate_car, grant_drv, target_speed);
        end
        leading_distance = 7'd14;
        tick();
        vectors++;
        if ({mode, brake_car} !== {3'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL brake_hyst: mode=%0d brk=%b, want 3 1", mode, brake_car);
        end
        leading_distance = 7'd15;
        tick();
        vectors++;
        if ({mode, brake_car, grant_drv, target_speed} !== {3'd1, 2'b01, 8'd25}) begin
            miscompares++;
            $display("FAIL brake_exit: mode=%0d brk=%b gd=%b tgt=%0d, want 1 0 1 25",
                     mode, brake_car, grant_drv, target_speed);
        end
        tick();
        vectors++;
        if ({target_speed, accelerate_car} !== {8'd27, 1'b1}) begin
            miscompares++;
            $display("FAIL post_brake_ramp: tgt=%0d acc=%b, want 27 1",
                     target_speed, accelerate_car);
        end
    endtask

    task automatic test_stop_and_unlock();
        drv_target = 8'd6;
        tick();
        vectors++;
        if (target_speed !== 8'd6) begin
            miscompares++;
            $display("FAIL clamp_down: tgt=%0d, want 6", target_speed);
        end
        drv_req = 1'b0; auto_req = 1'b0;
        tick();
        vectors++;
        if ({mode, target_speed, grant_drv} !== {3'd4, 8'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL stopping4: mode=%0d tgt=%0d gd=%b, want 4 4 0",
                     mode, target_speed, grant_drv);
        end
        tick();
        vectors++;
        if ({mode, target_speed} !== {3'd4, 8'd2}) begin
            miscompares++;
            $display("FAIL stopping2: mode=%0d tgt=%0d, want 4 2", mode, target_speed);
        end
        car_speed = 8'd0;
        tick();
        vectors++;
        if ({mode, target_speed} !== {3'd4, 8'd0}) begin
            miscompares++;
            $display("FAIL stopping0: mode=%0d tgt=%0d, want 4 0", mode, target_speed);
        end
        tick();
        vectors++;
        if ({mode, door_locked} !== {3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL to_idle: mode=%0d door=%b, want 0 1", mode, door_locked);
        end
        car_speed = 8'd5; unlock_doors = 1'b1;
        tick();
        vectors++;
        if ({mode, door_locked} !== {3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL unlock_moving: mode=%0d door=%b, want 0 1", mode, door_locked);
        end
        car_speed = 8'd0;
        tick();
        vectors++;
        if ({mode, door_locked} !== {3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL unlock_stopped: mode=%0d door=%b, want 0 0", mode, door_locked);
        end
        unlock_doors = 1'b0;
    endtask

    task automatic test_reset_in_brake();
        drv_req = 1'b1; leading_distance = 7'd100;
        tick();
        vectors++;
        if ({mode, door_locked} !== {3'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL relock: mode=%0d door=%b, want 1 1", mode, door_locked);
        end
        leading_distance = 7'd3;
        tick();
        vectors++;
        if ({mode, brake_car} !== {3'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL brake_again: mode=%0d brk=%b, want 3 1", mode, brake_car);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({mode, door_locked, grant_drv, grant_auto, brake_car, target_speed} !==
            {3'd0, 4'b1000, 8'd0}) begin
            miscompares++;
            $display("FAIL reset_in_brake: mode=%0d door=%b gd=%b ga=%b brk=%b tgt=%0d, want 0 1 0 0 0 0",
                     mode, door_locked, grant_drv, grant_auto, brake_car, target_speed);
        end
        rst = 1'b0; drv_req = 1'b0;
        tick();
    endtask

    task automatic test_no_wrap();
        speed_limit = 8'd255; drv_target = 8'd255; drv_req = 1'b1;
        car_speed = 8'd0; leading_distance = 7'd3;
        tick();
        vectors++;
        if ({mode, target_speed} !== {3'd1, 8'd2}) begin
            miscompares++;
            $display("FAIL idle_no_brake: mode=%0d tgt=%0d, want 1 2", mode, target_speed);
        end
        tick();
        car_speed = 8'd254; leading_distance = 7'd15;
        tick();
        vectors++;
        if ({mode, target_speed} !== {3'd1, 8'd254}) begin
            miscompares++;
            $display("FAIL load_254: mode=%0d tgt=%0d, want 1 254", mode, target_speed);
        end
        tick();
        vectors++;
        if ({target_speed, accelerate_car} !== {8'd255, 1'b1}) begin
            miscompares++;
            $display("FAIL top_255: tgt=%0d acc=%b, want 255 1", target_speed, accelerate_car);
        end
        tick();
        vectors++;
        if (target_speed !== 8'd255) begin
            miscompares++;
            $display("FAIL no_wrap: tgt=%0d, want 255", target_speed);
        end
    endtask

    initial begin
        rst = 1'b1;
        speed_limit = 8'd50; car_speed = 8'd0; leading_distance = 7'd100;
        unlock_doors = 1'b0; drv_req = 1'b0; drv_target = 8'd0;
        auto_req = 1'b0; auto_target = 8'd0;
        test_reset();
        test_ramp_up();
        test_preempt();
        test_brake();
        test_stop_and_unlock();
        test_reset_in_brake();
        test_no_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
